uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL provide parameter cpb, default 217, meaning clocks per bit; legal range 8..65535.
REQ-002 The module SHALL provide port clk, input, 1, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 The module SHALL provide port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The module SHALL provide port rx_serial_in, input, 1, the asynchronous serial line (idle high).
REQ-005 The module SHALL provide port rx_dv, output, 1, a one-clock pulse marking a valid received byte.
REQ-006 The module SHALL provide port rx_data_out, output, 8, the last valid byte received.
REQ-007 The module SHALL provide port rx_active, output, 1, high from start-bit detection until return to IDLE.
REQ-008 The module SHALL provide port rx_frame_err, output, 1, a one-clock pulse when the stop bit samples low.

Function
REQ-009 rx_serial_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-010 The FSM states SHALL be IDLE, START, DATA, STOP and CLEANUP, plus PARITY when the parity option is compiled in.
REQ-011 IDLE SHALL move to START only on a synchronized high-to-low transition, with the counter cleared and rx_active set.
REQ-012 START SHALL sample at count (cpb-1)/2: a low sample goes to DATA with the counter cleared; a high sample (glitch) returns to IDLE with no output pulse.
REQ-013 DATA SHALL sample each bit after cpb further clocks, shift it in LSB first, and move to STOP after bit index 7, using a 3-bit index.
REQ-014 STOP SHALL sample after cpb clocks: high means rx_data_out takes the shift register and rx_dv pulses; low means rx_frame_err pulses and rx_data_out is unchanged; both paths then go to CLEANUP.
REQ-015 CLEANUP SHALL last one clock, clear rx_active, and enter IDLE.
REQ-016 rx_dv and rx_frame_err SHALL never assert in the same cycle and SHALL each be exactly one clock wide.
REQ-017 The counter width SHALL be $clog2(cpb); it SHALL never wrap within a bit.
REQ-018 Line held low (break) SHALL yield one rx_frame_err, after which no new start is accepted until the line returns high and falls again.
REQ-019 rx_data_out SHALL hold its value between valid bytes.
REQ-020 A start edge arriving during CLEANUP SHALL still be detected in the following IDLE cycle, so a frame with one stop bit directly followed by a start bit is received.

Reset
REQ-021 rst SHALL asynchronously force: state IDLE, rx_dv 0, rx_data_out 8'h00, rx_active 0, rx_frame_err 0, counters 0, synchronizer flops 1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame without any pulse; reception SHALL resume on the next falling edge after deassertion.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL, when defined, add a PARITY state between DATA and STOP that samples an even-parity bit after cpb clocks.
REQ-024 With UART_RX_PARITY_EN defined, a 1-bit output rx_parity_err SHALL pulse one clock at the STOP decision on mismatch, and rx_dv SHALL be suppressed for that byte.
REQ-025 Without UART_RX_PARITY_EN, the PARITY state and rx_parity_err SHALL be absent and the frame SHALL be 8N1.

Structure
REQ-026 Package uart_pkg SHALL hold the state-encoding constants (shared with the transmitter) and the default CPB value 217.
REQ-027 The synchronizer SHALL be sub-module uart_sync_2ff (1-bit input, 1-bit output, reset value 1).

Verification (cpb=217; TX model drives 217 clocks/bit)
REQ-028 Byte 8'hA5, 8N1 -> exactly one rx_dv with rx_data_out=8'hA5, about 9.5 bit times plus 3 clocks after the start edge; rx_frame_err stays 0.
REQ-029 Low glitch of 50 clocks -> no rx_dv, no rx_frame_err; rx_active returns to 0 after about 108 clocks.
REQ-030 8'h3C with the stop bit driven low -> one rx_frame_err pulse, no rx_dv, rx_data_out keeps its previous value.
REQ-031 Back-to-back 8'h00 then 8'hFF with one stop bit each -> two rx_dv pulses, with data 8'h00 then 8'hFF.
REQ-032 rst pulsed during bit 4 of 8'h55, then 8'h81 sent -> all outputs 0 during reset, no pulse for 8'h55, rx_dv with 8'h81.
REQ-033 With UART_RX_PARITY_EN, 8'h03 with parity bit 1 -> rx_parity_err pulses, no rx_dv; 8'h03 with parity 0 -> rx_dv with 8'h03.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: default clocks-per-bit and the
//               receiver/transmitter state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default clocks per bit (e.g. 25 MHz / 115200 baud).
    localparam int c_CPB_DEFAULT = 217;

    // State encoding shared by the UART receiver and transmitter.
    localparam int         c_ST_W       = 3;
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_START   = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_PARITY  = 3'd3;
    localparam logic [2:0] c_ST_STOP    = 3'd4;
    localparam logic [2:0] c_ST_CLEANUP = 3'd5;

endpackage
`default_nettype wire

// File: rtl/uart_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit. Both
//               flops reset to 1 so an idle-high serial line never produces
//               a spurious falling edge out of reset.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               i_async - asynchronous input
//               o_sync  - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8 data bits LSB first, one stop bit. Samples
//               the middle of each bit using a clocks-per-bit counter.
//               Optional even-parity support is compiled in with the macro
//               UART_RX_PARITY_EN (adds PARITY state and rx_parity_err).
// Parameters  : cpb           - clocks per bit (8..65535)
// Ports       : clk           - system clock (rising edge)
//               rst           - asynchronous active-high reset
//               rx_serial_in  - asynchronous serial line, idle high
//               rx_dv         - one-clock pulse, rx_data_out holds a new byte
//               rx_data_out   - last valid byte received
//               rx_active     - high from start detection until back in IDLE
//               rx_frame_err  - one-clock pulse when the stop bit is low
//               rx_parity_err - (UART_RX_PARITY_EN only) one-clock pulse on
//                               parity mismatch; rx_dv is suppressed
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int cpb = c_CPB_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial_in,
    output logic       rx_dv,
    output logic [7:0] rx_data_out,
    output logic       rx_active,
    output logic       rx_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int                 c_CNT_W    = $clog2(cpb);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(cpb - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'((cpb - 1) / 2);

    logic               w_rx;
    logic [c_ST_W-1:0]  r_state,   w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shift,   w_shift_nxt;
    logic [7:0]         r_data,    w_data_nxt;
    logic               r_dv,      w_dv_nxt;
    logic               r_active,  w_active_nxt;
    logic               r_ferr,    w_ferr_nxt;
    // Set once the synchronized line has been seen high; a start is only
    // accepted while armed, which gives falling-edge detection that also
    // catches an edge landing in CLEANUP and blocks restarts during a break.
    logic               r_armed,   w_armed_nxt;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bad, w_par_bad_nxt;
    logic               r_perr,    w_perr_nxt;
`endif

    uart_sync_2ff u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx_serial_in),
        .o_sync  (w_rx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_dv      <= 1'b0;
            r_active  <= 1'b0;
            r_ferr    <= 1'b0;
            r_armed   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_dv      <= w_dv_nxt;
            r_active  <= w_active_nxt;
            r_ferr    <= w_ferr_nxt;
            r_armed   <= w_armed_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_dv_nxt      = 1'b0;
        w_ferr_nxt    = 1'b0;
        w_active_nxt  = r_active;
        w_armed_nxt   = r_armed | w_rx;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = '0;
                if (r_armed && !w_rx) begin
                    w_state_nxt  = c_ST_START;
                    w_active_nxt = 1'b1;
                    w_armed_nxt  = 1'b0;
                end
            end
            c_ST_START: begin
                if (r_cnt == c_CNT_MID) begin
                    w_cnt_nxt = '0;
                    if (!w_rx) begin
                        w_state_nxt = c_ST_DATA;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        w_state_nxt  = c_ST_IDLE;
                        w_active_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rx, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = c_ST_PARITY;
`else
                        w_state_nxt = c_ST_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt     = '0;
                    // Even parity: data bits plus parity bit XOR to zero.
                    w_par_bad_nxt = ^{r_shift, w_rx};
                    w_state_nxt   = c_ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            c_ST_STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_CLEANUP;
`ifdef UART_RX_PARITY_EN
                    w_perr_nxt  = r_par_bad;
                    if (w_rx && !r_par_bad) begin
`else
                    if (w_rx) begin
`endif
                        w_dv_nxt   = 1'b1;
                        w_data_nxt = r_shift;
                    end else if (!w_rx) begin
                        w_ferr_nxt  = 1'b1;
                        // Line is low at stop: require it to go high before
                        // another start is accepted (break handling).
                        w_armed_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_CLEANUP: begin
                w_state_nxt  = c_ST_IDLE;
                w_active_nxt = 1'b0;
            end
            default: begin
                w_state_nxt  = c_ST_IDLE;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    assign rx_dv        = r_dv;
    assign rx_data_out  = r_data;
    assign rx_active    = r_active;
    assign rx_frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A serial TX model drives
//               frames; each frame pushes its expected outcome (byte, frame
//               error or parity error) into a queue, and a monitor pops and
//               compares whenever the receiver pulses an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CPB = 217;
`ifdef UART_RX_PARITY_EN
    localparam int c_EXP_LAT = 2065 + c_CPB;
`else
    localparam int c_EXP_LAT = 2065;
`endif

    localparam logic [1:0] c_K_DV   = 2'd0;
    localparam logic [1:0] c_K_FERR = 2'd1;
    localparam logic [1:0] c_K_PERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial_in = 1'b1;
    logic       rx_dv;
    logic [7:0] rx_data_out;
    logic       rx_active;
    logic       rx_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(.cpb(c_CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_serial_in (rx_serial_in),
        .rx_dv        (rx_dv),
        .rx_data_out  (rx_data_out),
        .rx_active    (rx_active),
        .rx_frame_err (rx_frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_dv_cyc = -1;
    int         frame_start_cyc = 0;
    logic [7:0] model_last = 8'h00;

    // Monitor scratch
    logic       mon_ev;
    logic [1:0] mon_k;
    exp_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst) begin
            mon_ev = 1'b0;
            mon_k  = c_K_DV;
            if (rx_dv) begin
                mon_ev = 1'b1;
                mon_k  = c_K_DV;
                last_dv_cyc = cyc;
            end else if (rx_frame_err) begin
                mon_ev = 1'b1;
                mon_k  = c_K_FERR;
            end
`ifdef UART_RX_PARITY_EN
            else if (rx_parity_err) begin
                mon_ev = 1'b1;
                mon_k  = c_K_PERR;
            end
`endif
            if (mon_ev) begin
                check(!(rx_dv && rx_frame_err), "dv_ferr_exclusive",
                      {rx_dv, rx_frame_err}, 0);
                check(q.size() != 0, "event_expected", mon_k, 32'hFFFF);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    check(mon_k == mon_e.kind, "event_kind", mon_k, mon_e.kind);
                    check(rx_data_out == mon_e.data, "event_data",
                          rx_data_out, mon_e.data);
                end
            end
        end
    end

    // -------------------------------------------------------------- TX model
    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx_serial_in = b;
        repeat (c_CPB - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx_serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Reference: a frame with a low stop bit reports a frame error and keeps
    // the old byte; a parity mismatch reports a parity error and keeps the old
    // byte; otherwise the byte is delivered and becomes the held value.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input bit par_flip);
        exp_t e;
        if (!stop_ok) begin
            e.kind = c_K_FERR;
            e.data = model_last;
        end else if (par_flip) begin
            e.kind = c_K_PERR;
            e.data = model_last;
        end else begin
            e.kind = c_K_DV;
            e.data = d;
            model_last = d;
        end
        q.push_back(e);
        @(negedge clk);
        rx_serial_in = 1'b0;
        frame_start_cyc = cyc;
        repeat (c_CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_ok);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int lat;
        int t0;
        logic [7:0] rd;
        bit sok;
        bit pf;

        repeat (5) @(negedge clk);
        check(rx_dv == 1'b0,          "reset_dv",     rx_dv, 0);
        check(rx_frame_err == 1'b0,   "reset_ferr",   rx_frame_err, 0);
        check(rx_active == 1'b0,      "reset_active", rx_active, 0);
        check(rx_data_out == 8'h00,   "reset_data",   rx_data_out, 0);
        rst = 1'b0;
        idle_bits(20);

        // Single byte with latency measurement.
        send_frame(8'hA5, 1'b1, 1'b0);
        lat = last_dv_cyc - frame_start_cyc;
        check(lat >= c_EXP_LAT - 3 && lat <= c_EXP_LAT + 3, "a5_latency",
              lat, c_EXP_LAT);
        idle_bits(c_CPB);

        // 50-clock low glitch: active briefly, no pulses.
        @(negedge clk);
        rx_serial_in = 1'b0;
        t0 = cyc;
        repeat (50) @(negedge clk);
        rx_serial_in = 1'b1;
        while (cyc < t0 + 60) @(negedge clk);
        check(rx_active == 1'b1, "glitch_active_high", rx_active, 1);
        while (cyc < t0 + 120) @(negedge clk);
        check(rx_active == 1'b0, "glitch_active_low", rx_active, 0);
        idle_bits(c_CPB);

        // Bad stop bit keeps previous data.
        send_frame(8'h3C, 1'b0, 1'b0);
        idle_bits(2 * c_CPB);
        check(rx_data_out == model_last, "ferr_data_held", rx_data_out, model_last);

        // Back-to-back frames, one stop bit each.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle_bits(c_CPB);

        // Break: line held low for 12 bit times -> one frame error only.
        begin
            exp_t e;
            e.kind = c_K_FERR;
            e.data = model_last;
            q.push_back(e);
        end
        @(negedge clk);
        rx_serial_in = 1'b0;
        repeat (12 * c_CPB) @(negedge clk);
        idle_bits(3 * c_CPB);
        check(q.size() == 0, "break_single_ferr", q.size(), 0);
        check(rx_active == 1'b0, "break_active_low", rx_active, 0);
        check(rx_data_out == model_last, "break_data_held", rx_data_out, model_last);

        // Reset during bit 4 of 8'h55, then 8'h81.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rd_bit(8'h55, i));
        @(negedge clk);
        rx_serial_in = 1'b1;
        repeat (100) @(negedge clk);
        check(rx_active == 1'b1, "pre_reset_active", rx_active, 1);
        rst = 1'b1;
        #1;
        check(rx_dv == 1'b0,        "midrst_dv",     rx_dv, 0);
        check(rx_frame_err == 1'b0, "midrst_ferr",   rx_frame_err, 0);
        check(rx_active == 1'b0,    "midrst_active", rx_active, 0);
        check(rx_data_out == 8'h00, "midrst_data",   rx_data_out, 0);
        model_last = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bits(2 * c_CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(c_CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        idle_bits(c_CPB);
        send_frame(8'h03, 1'b1, 1'b0);
        idle_bits(c_CPB);
`endif

        // Randomized frames with random gaps and occasional stop errors.
        for (int n = 0; n < 12; n++) begin
            rd  = 8'($urandom);
            sok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            pf  = sok && ($urandom_range(0, 3) == 0);
`else
            pf  = 1'b0;
`endif
            send_frame(rd, sok, pf);
            if (!sok) idle_bits(c_CPB + $urandom_range(0, 300));
            else if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 300));
        end
        idle_bits(c_CPB);

        // Drain: every expected event must have been seen.
        t0 = cyc;
        while (q.size() != 0 && cyc < t0 + 20 * c_CPB) @(negedge clk);
        check(q.size() == 0, "scoreboard_drained", q.size(), 0);
        check(rx_active == 1'b0, "final_idle", rx_active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic rd_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

    // Global watchdog.
    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
